// File: rtl/wshb_arbiter_2.sv
// wshb_arbiter_2: two-master round-robin Wishbone arbiter with a per-grant ack quantum.
// Define WSHB_ARB_URGENT_EN to add m0_urgent_i, which lets M0 preempt M1 on M1's next ack.
module wshb_arbiter_2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int QUANTUM = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_ms_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    output logic                m0_ack_o,
    output logic [DATA_W-1:0]   m0_dat_sm_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_ms_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m1_dat_sm_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_ms_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    input  logic                s_ack_i,
`ifdef WSHB_ARB_URGENT_EN
    input  logic                m0_urgent_i,
`endif
    input  logic [DATA_W-1:0]   s_dat_sm_i
);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state_q;
    state_t          other;
    logic            last_q;
    logic [QW-1:0]   qcnt_q;
    logic            g0, g1, cur_cyc, oth_cyc, urgent, handoff;

    assign g0      = state_q == GNT0;
    assign g1      = state_q == GNT1;
    assign other   = g1 ? GNT0 : GNT1;
    assign cur_cyc = g1 ? m1_cyc_i : m0_cyc_i;
    assign oth_cyc = g1 ? m0_cyc_i : m1_cyc_i;
`ifdef WSHB_ARB_URGENT_EN
    assign urgent  = m0_urgent_i;
`else
    assign urgent  = 1'b0;
`endif
    // Hand over only on an ack, so the transfer in flight always completes to its owner
    assign handoff = s_ack_i && oth_cyc && (qcnt_q == QMAX || (g1 && urgent));

    assign s_cyc_o     = (g0 && m0_cyc_i) || (g1 && m1_cyc_i);
    assign s_stb_o     = (g0 && m0_stb_i) || (g1 && m1_stb_i);
    assign s_we_o      = (g0 && m0_we_i) || (g1 && m1_we_i);
    assign s_adr_o     = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_ms_o  = g0 ? m0_dat_ms_i : g1 ? m1_dat_ms_i : '0;
    assign s_sel_o     = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    assign m0_ack_o    = g0 && s_ack_i;
    assign m1_ack_o    = g1 && s_ack_i;
    assign m0_dat_sm_o = g0 ? s_dat_sm_i : '0;
    assign m1_dat_sm_o = g1 ? s_dat_sm_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            qcnt_q  <= '0;
        end else if (state_q == IDLE) begin
            qcnt_q <= '0;
            if (m0_cyc_i && (!m1_cyc_i || last_q || urgent))
                state_q <= GNT0;
            else if (m1_cyc_i)
                state_q <= GNT1;
        end else if (!cur_cyc || handoff) begin
            state_q <= oth_cyc ? other : IDLE;
            last_q  <= g1;
            qcnt_q  <= '0;
        end else if (s_ack_i && qcnt_q != QMAX) begin
            qcnt_q <= qcnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_wshb_arbiter_2.sv
// tb_wshb_arbiter_2: directed vector table, reset corner cases and a randomized run
// against a grant/quantum reference model for wshb_arbiter_2 with QUANTUM=4.
module tb_wshb_arbiter_2;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr [2];
    logic [31:0] dmo [2];
    logic [3:0]  sel [2];
    logic        s_ack;
    logic [31:0] s_dat;
`ifdef WSHB_ARB_URGENT_EN
    logic        urg;
`endif
    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we;
    logic [31:0] m0_dat, m1_dat, s_adr, s_dms;
    logic [3:0]  s_sel;
    logic [136:0] act;

    int errors = 0;
    int checks = 0;
    int own, lastm, served;

    always #5 clk = ~clk;

    wshb_arbiter_2 #(.ADDR_W(32), .DATA_W(32), .QUANTUM(Q)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
        .m0_dat_ms_i(dmo[0]), .m0_sel_i(sel[0]), .m0_ack_o(m0_ack), .m0_dat_sm_o(m0_dat),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
        .m1_dat_ms_i(dmo[1]), .m1_sel_i(sel[1]), .m1_ack_o(m1_ack), .m1_dat_sm_o(m1_dat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_ms_o(s_dms), .s_sel_o(s_sel), .s_ack_i(s_ack),
`ifdef WSHB_ARB_URGENT_EN
        .m0_urgent_i(urg),
`endif
        .s_dat_sm_i(s_dat)
    );

    assign act = {s_cyc, s_stb, s_we, s_adr, s_dms, s_sel, m0_ack, m0_dat, m1_ack, m1_dat};

    task automatic chk(input string name, input logic [136:0] got, input logic [136:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected outputs: the owner's request passes through, everyone else sees zeros
    function automatic logic [136:0] expect_out();
        if (own < 0) return '0;
        return {cyc[own], stb[own], we[own], adr[own], dmo[own], sel[own],
                own == 0 && s_ack, own == 0 ? s_dat : 32'h0,
                own == 1 && s_ack, own == 1 ? s_dat : 32'h0};
    endfunction

    // Grant bookkeeping: owner index, last served master, acks served in this grant
    task automatic model_step();
        int o;
        bit u = 1'b0;
`ifdef WSHB_ARB_URGENT_EN
        u = urg;
`endif
        if (own < 0) begin
            if (cyc[0] && cyc[1]) own = u ? 0 : 1 - lastm;
            else if (cyc[0]) own = 0;
            else if (cyc[1]) own = 1;
            served = 0;
        end else begin
            o = 1 - own;
            if (!cyc[own]) begin
                lastm = own;
                own = cyc[o] ? o : -1;
                served = 0;
            end else if (s_ack) begin
                served++;
                if (cyc[o] && (served >= Q || (own == 1 && u))) begin
                    lastm = own;
                    own = o;
                    served = 0;
                end
            end
        end
    endtask

    typedef struct {
        logic m0c, m1c, ack;
        int   own;
        logic a0, a1;
    } vec_t;
    vec_t tv [21];

    task automatic drive(input logic c0, input logic c1, input logic a);
        cyc = {c1, c0};
        stb = {c1, c0};
        s_ack = a;
    endtask

    initial begin
        logic [31:0] ea;
        tv[0]  = '{1, 0, 0, -1, 0, 0};
        tv[1]  = '{1, 0, 1,  0, 1, 0};
        tv[2]  = '{1, 0, 0,  0, 0, 0};
        tv[3]  = '{1, 0, 1,  0, 1, 0};
        tv[4]  = '{1, 1, 1,  0, 1, 0};
        tv[5]  = '{1, 1, 1,  0, 1, 0};
        tv[6]  = '{1, 1, 1,  1, 0, 1};
        tv[7]  = '{1, 1, 1,  1, 0, 1};
        tv[8]  = '{1, 1, 1,  1, 0, 1};
        tv[9]  = '{1, 1, 1,  1, 0, 1};
        tv[10] = '{1, 1, 1,  0, 1, 0};
        tv[11] = '{1, 1, 1,  0, 1, 0};
        tv[12] = '{0, 1, 0,  0, 0, 0};
        tv[13] = '{0, 1, 0,  1, 0, 0};
        tv[14] = '{0, 0, 0,  1, 0, 0};
        tv[15] = '{0, 0, 1, -1, 0, 0};
        tv[16] = '{1, 1, 0, -1, 0, 0};
        tv[17] = '{1, 1, 0,  0, 0, 0};
        tv[18] = '{0, 0, 0,  0, 0, 0};
        tv[19] = '{1, 1, 0, -1, 0, 0};
        tv[20] = '{1, 1, 0,  1, 0, 0};

        rst_n = 1'b0;
        drive(1, 0, 1);
        we = 2'b00;
        adr[0] = 32'hA0; adr[1] = 32'hB1;
        dmo[0] = 32'h1111_0000; dmo[1] = 32'h2222_0000;
        sel[0] = 4'hF; sel[1] = 4'h3;
        s_dat = 32'hCAFE_F00D;
`ifdef WSHB_ARB_URGENT_EN
        urg = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", act, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tv[i].m0c, tv[i].m1c, tv[i].ack);
            #1;
            ea = tv[i].own < 0 ? 32'h0 : adr[tv[i].own];
            chk($sformatf("tv%0d s_adr", i), 137'(s_adr), 137'(ea));
            chk($sformatf("tv%0d s_cyc", i), 137'(s_cyc),
                137'(tv[i].own == 0 ? tv[i].m0c : tv[i].own == 1 ? tv[i].m1c : 1'b0));
            chk($sformatf("tv%0d m0_ack", i), 137'(m0_ack), 137'(tv[i].a0));
            chk($sformatf("tv%0d m1_ack", i), 137'(m1_ack), 137'(tv[i].a1));
        end

        // Reset pulse while M1 owns the bus with an ack pending
        @(negedge clk);
        drive(1, 1, 1);
        rst_n = 1'b0;
        #1 chk("rst_mid_s_cyc", 137'(s_cyc), 137'(1'b0));
        chk("rst_mid_m1_ack", 137'(m1_ack), 137'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0);
        #1 chk("rst_rel_idle", 137'(s_cyc), 137'(1'b0));
        @(negedge clk);
        #1 chk("rst_rel_m0_first", 137'(s_adr), 137'(32'hA0));

        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        own = -1; lastm = 1; served = 0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(7) == 0) cyc[m] = ~cyc[m];
                stb[m] = cyc[m];
                we[m]  = 1'($urandom);
                adr[m] = $urandom;
                dmo[m] = $urandom;
                sel[m] = 4'($urandom);
            end
            s_ack = $urandom_range(3) != 0;
            s_dat = $urandom;
`ifdef WSHB_ARB_URGENT_EN
            urg = $urandom_range(3) == 0;
`endif
            #1 chk($sformatf("rand%0d", n), act, expect_out());
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
